// File: rtl/traffic_light_pkg.sv
// Shared types and display helpers for the multi-phase traffic light controller.
// Optional night-flash mode is enabled with `define TL_NIGHT_FLASH_EN.
package traffic_light_pkg;

`ifdef TL_NIGHT_FLASH_EN
    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} tl_state_e;
`else
    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} tl_state_e;
`endif

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_t;

    // Active-low segments ordered {g,f,e,d,c,b,a}; non-decimal codes go blank.
    function automatic logic [6:0] seg7_dec(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic bcd_t bin2bcd(input logic [6:0] v);
        bcd_t r;
        r.tens = 4'(v / 7'd10);
        r.ones = 4'(v % 7'd10);
        return r;
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// One-second strobe: a single-cycle pulse every CLK_HZ clocks, first pulse
// CLK_HZ cycles after reset release.
module tl_tick_gen #(
    parameter int CLK_HZ = 20000000
) (
    input  logic clk20M,
    input  logic Reset_n,
    output logic tick
);

    localparam int             W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0]   LAST = W'(CLK_HZ - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk20M) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!Reset_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/traffic_light_multi.sv
// Round-robin GREEN/YELLOW/ALL-RED controller for NUM_PHASES approaches with
// pedestrian shortening and 7-segment countdown. Night flash: TL_NIGHT_FLASH_EN.
module traffic_light_multi
    import traffic_light_pkg::*;
#(
    parameter int CLK_HZ        = 20000000,
    parameter int NUM_PHASES    = 2,
    parameter int GREEN_SEC     = 25,
    parameter int YELLOW_SEC    = 3,
    parameter int ALLRED_SEC    = 2,
    parameter int PED_GREEN_SEC = 5
) (
    input  logic                  clk20M,
    input  logic                  Reset_n,
    input  logic                  ped_req,
`ifdef TL_NIGHT_FLASH_EN
    input  logic                  night,
`endif
    output logic [NUM_PHASES-1:0] LR,
    output logic [NUM_PHASES-1:0] LY,
    output logic [NUM_PHASES-1:0] LG,
    output logic [6:0]            HEX0,
    output logic [6:0]            HEX1,
    output logic [6:0]            HEX2,
    output logic [6:0]            HEX3,
    output logic                  ped_pending
);

    localparam int              PW       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam logic [PW-1:0]   PH_LAST  = PW'(NUM_PHASES - 1);
    localparam logic [6:0]      GREEN_L  = 7'(GREEN_SEC);
    localparam logic [6:0]      YELLOW_L = 7'(YELLOW_SEC);
    localparam logic [6:0]      ALLRED_L = 7'(ALLRED_SEC);
    localparam logic [6:0]      PED_L    = 7'(PED_GREEN_SEC);

    logic                  tick;
    tl_state_e             state, state_n;
    logic [PW-1:0]         ph, ph_n;
    logic [6:0]            cnt, cnt_n;
    logic                  pend_n;
    logic [NUM_PHASES-1:0] sel, lr_n, ly_n, lg_n;
`ifdef TL_NIGHT_FLASH_EN
    logic                  flash_ly, flash_ly_n;
`endif

    tl_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk20M  (clk20M),
        .Reset_n (Reset_n),
        .tick    (tick)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves a latch.
        state_n = state;
        ph_n    = ph;
        cnt_n   = cnt;
        pend_n  = ped_pending | ped_req;
`ifdef TL_NIGHT_FLASH_EN
        flash_ly_n = flash_ly;
`endif
        case (state)
            S_GREEN: begin
                // Pedestrian shortening wins over a same-cycle tick decrement.
                if ((ped_pending || ped_req) && cnt > PED_L) begin
                    cnt_n = PED_L;
                end else if (tick) begin
                    if (cnt > 7'd1) begin
                        cnt_n = cnt - 7'd1;
                    end else begin
                        state_n = S_YELLOW;
                        cnt_n   = YELLOW_L;
                        pend_n  = 1'b0;
                    end
                end
            end
            S_YELLOW: begin
                if (tick) begin
                    if (cnt > 7'd1) begin
                        cnt_n = cnt - 7'd1;
                    end else begin
                        state_n = S_ALLRED;
                        cnt_n   = ALLRED_L;
                    end
                end
            end
            S_ALLRED: begin
                if (tick) begin
                    if (cnt > 7'd1) begin
                        cnt_n = cnt - 7'd1;
                    end else begin
                        state_n = S_GREEN;
                        cnt_n   = GREEN_L;
                        ph_n    = (ph == PH_LAST) ? '0 : ph + 1'b1;
                    end
                end
            end
`ifdef TL_NIGHT_FLASH_EN
            S_FLASH: begin
                pend_n = ped_pending;
                if (tick) begin
                    state_n = S_ALLRED;
                    cnt_n   = ALLRED_L;
                    ph_n    = PH_LAST;
                end
            end
`endif
            default: ;
        endcase
`ifdef TL_NIGHT_FLASH_EN
        // Night on a tick overrides whatever the sequencer decided above.
        if (tick && night) begin
            state_n    = S_FLASH;
            cnt_n      = cnt;
            ph_n       = ph;
            pend_n     = (state == S_FLASH) ? ped_pending : (ped_pending | ped_req);
            flash_ly_n = (state == S_FLASH) ? ~flash_ly : 1'b1;
        end
`endif
    end

    // Lamp pattern for the next state, so the lamp flops track the state flops.
    always_comb begin
        sel  = {{(NUM_PHASES-1){1'b0}}, 1'b1} << ph_n;
        lr_n = '1;
        ly_n = '0;
        lg_n = '0;
        case (state_n)
            S_GREEN: begin
                lg_n = sel;
                lr_n = ~sel;
            end
            S_YELLOW: begin
                ly_n = sel;
                lr_n = ~sel;
            end
`ifdef TL_NIGHT_FLASH_EN
            S_FLASH: begin
                lr_n = '0;
                ly_n = {NUM_PHASES{flash_ly_n}};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk20M) begin
        if (!Reset_n) begin
            state       <= S_ALLRED;
            cnt         <= ALLRED_L;
            ph          <= PH_LAST;
            ped_pending <= 1'b0;
            LR          <= '1;
            LY          <= '0;
            LG          <= '0;
`ifdef TL_NIGHT_FLASH_EN
            flash_ly    <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            ph          <= ph_n;
            ped_pending <= pend_n;
            LR          <= lr_n;
            LY          <= ly_n;
            LG          <= lg_n;
`ifdef TL_NIGHT_FLASH_EN
            flash_ly    <= flash_ly_n;
`endif
        end
    end

    bcd_t       bcd;
    logic [3:0] ph_digit;

    assign bcd      = bin2bcd(cnt);
    assign ph_digit = 4'(ph) + 4'd1;

    always_comb begin
        HEX0 = seg7_dec(bcd.ones);
        HEX1 = (bcd.tens == 4'd0) ? SEG_BLANK : seg7_dec(bcd.tens);
        HEX2 = seg7_dec(ph_digit);
        HEX3 = SEG_BLANK;
`ifdef TL_NIGHT_FLASH_EN
        if (state == S_FLASH) begin
            HEX0 = SEG_BLANK;
            HEX1 = SEG_BLANK;
            HEX2 = SEG_BLANK;
        end
`endif
    end

endmodule

// File: tb/tb_traffic_light_multi.sv
// Bench for traffic_light_multi: a seconds-level behavioural model compared every
// cycle, plus directed vectors with literal expectations along a fixed timeline.
module tb_traffic_light_multi;

    localparam int CLK_HZ = 4;
    localparam int NP     = 3;
    localparam int G      = 6;
    localparam int Y      = 2;
    localparam int A      = 1;
    localparam int PED    = 2;

    logic          clk = 1'b0;
    logic          Reset_n;
    logic          ped_req;
`ifdef TL_NIGHT_FLASH_EN
    logic          night;
`endif
    logic [NP-1:0] LR, LY, LG;
    logic [6:0]    HEX0, HEX1, HEX2, HEX3;
    logic          ped_pending;

    int checks = 0;
    int errors = 0;
    int now_n  = 0;

    always #5 clk = ~clk;

    traffic_light_multi #(
        .CLK_HZ(CLK_HZ), .NUM_PHASES(NP), .GREEN_SEC(G),
        .YELLOW_SEC(Y), .ALLRED_SEC(A), .PED_GREEN_SEC(PED)
    ) dut (
        .clk20M      (clk),
        .Reset_n     (Reset_n),
        .ped_req     (ped_req),
`ifdef TL_NIGHT_FLASH_EN
        .night       (night),
`endif
        .LR          (LR),
        .LY          (LY),
        .LG          (LG),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .ped_pending (ped_pending)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %0h expected %0h", name, now_n, act, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int dur(input int mode);
        if (mode == 0) return G;
        if (mode == 1) return Y;
        return A;
    endfunction

    // Model: mode 0=green 1=yellow 2=all-red 3=flash; m_left = seconds left in mode.
    int m_mode, m_ph, m_left, m_tc;
    bit m_pend, m_fl, m_ok = 0, m_tick, m_req;

    always @(posedge clk) begin
        if (!Reset_n) begin
            m_mode = 2; m_left = A; m_ph = NP - 1; m_pend = 0; m_tc = 0; m_fl = 0; m_ok = 1;
        end else if (m_ok) begin
            m_tick = (m_tc == CLK_HZ - 1);
            m_tc   = m_tick ? 0 : m_tc + 1;
            m_req  = m_pend || ped_req;
            if (m_mode != 3) m_pend = m_req;
`ifdef TL_NIGHT_FLASH_EN
            if (m_tick && night) begin
                if (m_mode == 3) m_fl = !m_fl;
                else begin m_mode = 3; m_fl = 1; end
            end else if (m_mode == 3) begin
                if (m_tick) begin m_mode = 2; m_left = A; m_ph = NP - 1; end
            end else
`endif
            if (m_mode == 0 && m_req && m_left > PED) begin
                m_left = PED;
            end else if (m_tick) begin
                if (m_left > 1) m_left--;
                else begin
                    m_mode = (m_mode + 1) % 3;
                    if (m_mode == 0) m_ph = (m_ph + 1) % NP;
                    if (m_mode == 1) m_pend = 0;
                    m_left = dur(m_mode);
                end
            end
        end
    end

    logic [NP-1:0] e_r, e_y, e_g;
    logic [6:0]    e_h0, e_h1, e_h2;
    bit            lamp_ok;
    int            nonred;

    always @(negedge clk) begin
        if (m_ok) begin
            e_r = '1; e_y = '0; e_g = '0;
            e_h0 = 7'h7F; e_h1 = 7'h7F; e_h2 = 7'h7F;
            if (m_mode == 0) begin e_g[m_ph] = 1'b1; e_r[m_ph] = 1'b0; end
            if (m_mode == 1) begin e_y[m_ph] = 1'b1; e_r[m_ph] = 1'b0; end
            if (m_mode == 3) begin e_r = '0; e_y = {NP{m_fl}}; end
            if (m_mode != 3) begin
                e_h0 = seg(m_left % 10);
                e_h1 = (m_left / 10 == 0) ? 7'h7F : seg(m_left / 10);
                e_h2 = seg(m_ph + 1);
            end
            check("model_LR", LR, e_r);
            check("model_LY", LY, e_y);
            check("model_LG", LG, e_g);
            check("model_HEX0", HEX0, e_h0);
            check("model_HEX1", HEX1, e_h1);
            check("model_HEX2", HEX2, e_h2);
            check("model_HEX3", HEX3, 7'h7F);
            check("model_ped_pending", ped_pending, m_pend);
            if (m_mode != 3) begin
                lamp_ok = 1;
                nonred  = 0;
                for (int p = 0; p < NP; p++) begin
                    if (int'(LR[p]) + int'(LY[p]) + int'(LG[p]) != 1) lamp_ok = 0;
                    if (LY[p] || LG[p]) nonred++;
                end
                if (nonred > 1) lamp_ok = 0;
                check("lamp_rule", lamp_ok, 1);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        now_n++;
    endtask

    task automatic go_to(input int n);
        while (now_n < n) step();
    endtask

    int            g_cyc, y_cyc, r_cyc;
    logic [NP-1:0] prev_lg;
    logic [NP-1:0] ons[$];

    initial begin
        Reset_n = 1'b0;
        ped_req = 1'b0;
`ifdef TL_NIGHT_FLASH_EN
        night   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_LR", LR, 3'b111);
        check("rst_LG", LG, 3'b000);
        check("rst_HEX0", HEX0, 7'h79);
        check("rst_HEX1", HEX1, 7'h7F);
        check("rst_HEX2", HEX2, 7'h30);
        check("rst_ped", ped_pending, 1'b0);

        Reset_n = 1'b1;
        now_n   = 0;
        go_to(3);
        check("pre_tick_LR", LR, 3'b111);
        go_to(4);
        check("first_green_LG", LG, 3'b001);
        check("first_green_HEX0", HEX0, 7'h02);
        check("first_green_HEX2", HEX2, 7'h79);

        // Three full rounds: n4..n112 inclusive.
        g_cyc = 0; y_cyc = 0; r_cyc = 0; prev_lg = '0;
        for (int i = 0; i < 109; i++) begin
            if (i > 0) step();
            if (LG != 0) g_cyc++;
            else if (LY != 0) y_cyc++;
            else r_cyc++;
            if (LG != 0 && prev_lg == 0) ons.push_back(LG);
            prev_lg = LG;
        end
        check("green_cycles", g_cyc, 73);
        check("yellow_cycles", y_cyc, 24);
        check("allred_cycles", r_cyc, 12);
        check("onset_count", ons.size(), 4);
        if (ons.size() == 4) begin
            check("order_0", ons[0], 3'b001);
            check("order_1", ons[1], 3'b010);
            check("order_2", ons[2], 3'b100);
            check("order_3", ons[3], 3'b001);
        end

        // Pedestrian pulse at green count 5.
        go_to(116);
        check("ped_before_HEX0", HEX0, 7'h12);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check("ped_short_HEX0", HEX0, 7'h24);
        check("ped_latched", ped_pending, 1'b1);
        go_to(123);
        check("ped_last_green_LG", LG, 3'b001);
        check("ped_last_green_HEX0", HEX0, 7'h79);
        go_to(124);
        check("ped_yellow_LY", LY, 3'b001);
        check("ped_cleared", ped_pending, 1'b0);

        // Request coincident with the first tick of phase 1 green.
        go_to(139);
        check("coinc_pre_LG", LG, 3'b010);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check("coinc_HEX0", HEX0, 7'h24);
        check("coinc_ped", ped_pending, 1'b1);
        go_to(148);
        check("coinc_yellow_LY", LY, 3'b010);

        // Request during yellow shortens the next green.
        go_to(150);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check("yel_req_ped", ped_pending, 1'b1);
        go_to(160);
        check("next_green_LG", LG, 3'b100);
        check("next_green_HEX0", HEX0, 7'h02);
        check("next_green_HEX2", HEX2, 7'h30);
        step();
        check("next_green_short", HEX0, 7'h24);
        go_to(167);
        check("next_green_end_LG", LG, 3'b100);
        go_to(168);
        check("next_yellow_LY", LY, 3'b100);

        // Reset pulse mid-yellow.
        go_to(170);
        check("mid_yellow_LY", LY, 3'b100);
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        check("mid_rst_LR", LR, 3'b111);
        check("mid_rst_HEX0", HEX0, 7'h79);
        check("mid_rst_HEX2", HEX2, 7'h30);
        check("mid_rst_ped", ped_pending, 1'b0);
        go_to(174);
        check("mid_rst_wait_LR", LR, 3'b111);
        go_to(175);
        check("mid_rst_green_LG", LG, 3'b001);
        check("mid_rst_green_HEX0", HEX0, 7'h02);

`ifdef TL_NIGHT_FLASH_EN
        go_to(176);
        night = 1'b1;
        go_to(179);
        check("flash_LY_on", LY, 3'b111);
        check("flash_LR", LR, 3'b000);
        check("flash_LG", LG, 3'b000);
        check("flash_HEX0", HEX0, 7'h7F);
        check("flash_HEX2", HEX2, 7'h7F);
        go_to(183);
        check("flash_LY_off", LY, 3'b000);
        go_to(184);
        night = 1'b0;
        go_to(187);
        check("flash_exit_LR", LR, 3'b111);
        check("flash_exit_HEX0", HEX0, 7'h79);
        go_to(191);
        check("flash_exit_green", LG, 3'b001);
`endif

        go_to(230);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
